dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer that shares the single data-memory/cache port between the core datapath (requester 0) and a secondary master such as a loader or debug port (requester 1). It serialises requests, latches the winning request, and holds it on the memory side until the memory signals completion or a timeout expires. It then returns a one-cycle response to the granted requester. It sits between the datapath/loader and the data memory or cache.

## Interface
- ADDR_SIZE, 32, address width
- DATA_SIZE, 32, data width
- TIMEOUT, 64, maximum BUSY cycles without mem_ready before the access is aborted (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rN_req  in  1  requester N (N=0,1) access request; held until rN_ready
- rN_addr  in  ADDR_SIZE  requester N address; stable while rN_req=1
- rN_we  in  1  requester N write enable
- rN_wdata  in  DATA_SIZE  requester N write data
- rN_rdata  out  DATA_SIZE  read data; valid when rN_ready=1
- rN_ready  out  1  one-cycle completion pulse to requester N
- mem_valid  out  1  memory access active
- mem_addr  out  ADDR_SIZE  latched address
- mem_write_enable  out  1  latched write enable, gated by mem_valid
- mem_write_data  out  DATA_SIZE  latched write data
- mem_read_data  in  DATA_SIZE  memory read data, sampled when mem_ready=1
- mem_ready  in  1  memory completion; only meaningful while mem_valid=1
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any rN_req is high, select a winner and latch addr, we and wdata into registers. Record the grant, clear the timeout counter, and go to BUSY.
  - If both request, grant the requester other than last_grant (round-robin). Otherwise grant the sole requester.
  - last_grant updates on every grant.
- BUSY:
  - mem_valid=1. mem_addr, mem_write_enable and mem_write_data are driven from the latches and do not change while in BUSY.
  - On mem_ready=1: capture mem_read_data into the response register (captured for writes too) and go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no mem_ready, set err, load 0 into the response register, and go to RESP.
- RESP:
  - mem_valid=0.
  - The granted rN_ready=1 for exactly this cycle. Both rN_rdata outputs show the response register.
  - The other requester's ready stays 0.
  - Always return to IDLE.
- Requester rule: deassert req, or present a new request, on the edge that samples rN_ready=1. A req still high in IDLE is treated as a new access.
- A non-granted requester keeps waiting and is not starved: it wins the next arbitration because of the round-robin.
- err clears only on reset.
- mem_write_enable = latched_we & mem_valid. It is never high outside BUSY.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=1 (so r0 wins first contention), counter=0.
  - All outputs 0: rN_ready, rN_rdata, mem_valid, mem_addr, mem_write_enable, mem_write_data, err.
- Reset during BUSY or RESP abandons the access; no ready pulse is issued after reset is released.
- Latency, with request sampled at edge k:
  - mem_valid is high from cycle k+1.
  - If mem_ready is high in cycle k+1+d, rN_ready is high in cycle k+2+d.
  - Minimum request-to-ready latency is 2 cycles. Minimum back-to-back throughput is one access per 3 cycles.
- Timeout: when mem_ready never arrives, the BUSY duration is exactly TIMEOUT cycles, then one RESP cycle.
- mem_ready in the same cycle as the timeout terminal count: mem_ready wins. Data is captured and err is not set.
- Request inputs are ignored outside IDLE. mem_ready is ignored outside BUSY.

## Test plan
- Single read: r0_req, addr=0x64, we=0. mem_ready in the first BUSY cycle with mem_read_data=0x19 -> r0_ready pulses 2 cycles after the request and r0_rdata=0x19. r1_ready stays 0.
- Write pass-through: r1 writes addr=0x60, data=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_write_enable=1 for exactly 4 cycles with stable addr/data, and r1_ready pulses once.
- Contention: r0 and r1 request in the same cycle after reset, held until served -> r0 is granted first, r1 next. Repeating simultaneous requests alternates grants r0, r1, r0, r1.
- Timeout: TIMEOUT=4, mem_ready held 0 -> mem_valid high 4 cycles, then r0_ready pulses with rdata=0 and err=1. err stays 1 through the following normal accesses.
- Timeout race: mem_ready arrives on the terminal BUSY cycle with data 0xA5 -> rdata=0xA5 and err stays 0.
- Async reset mid-BUSY: rst low for 1 cycle -> mem_valid and mem_write_enable drop immediately, no rN_ready pulse follows, and the next r1-only request is granted normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core datapath (r0)
// and a secondary master (r1). One access is in flight at a time. The winning
// request is latched and held on the memory side until mem_ready arrives or
// the timeout expires. A one-cycle ready pulse then goes back to the winner.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no access in flight; arbitrate between pending requests
//   BUSY  | latched access driven to memory; wait for mem_ready/timeout
//   RESP  | one-cycle ready pulse to the granted requester
module dmem_arbiter #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r0_req,
  input  logic [ADDR_SIZE-1:0] r0_addr,
  input  logic                 r0_we,
  input  logic [DATA_SIZE-1:0] r0_wdata,
  output logic [DATA_SIZE-1:0] r0_rdata,
  output logic                 r0_ready,
  input  logic                 r1_req,
  input  logic [ADDR_SIZE-1:0] r1_addr,
  input  logic                 r1_we,
  input  logic [DATA_SIZE-1:0] r1_wdata,
  output logic [DATA_SIZE-1:0] r1_rdata,
  output logic                 r1_ready,
  output logic                 mem_valid,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_write_enable,
  output logic [DATA_SIZE-1:0] mem_write_data,
  input  logic [DATA_SIZE-1:0] mem_read_data,
  input  logic                 mem_ready,
  output logic                 err
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TERM_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic                 sel;
  logic                 timeout_hit;
  logic                 grant;
  logic                 last_grant;
  logic [CW-1:0]        cnt;
  logic [ADDR_SIZE-1:0] lat_addr;
  logic                 lat_we;
  logic [DATA_SIZE-1:0] lat_wdata;
  logic [DATA_SIZE-1:0] resp_data;
  logic                 err_q;

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic plus round-robin winner selection.
  always_comb begin
    state_nx    = state;
    timeout_hit = 1'b0;
    // Contention goes to whoever did not win last; otherwise the sole requester.
    if (r0_req && r1_req) sel = ~last_grant;
    else                  sel = r1_req;
    case (state)
      IDLE: begin
        if (r0_req || r1_req) state_nx = BUSY;
      end
      BUSY: begin
        // mem_ready beats the terminal count when both land in the same cycle.
        if (mem_ready) begin
          state_nx = RESP;
        end else if (cnt == TERM_CNT) begin
          state_nx    = RESP;
          timeout_hit = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant bookkeeping, request latches, timeout counter, response and err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      resp_data  <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            grant      <= sel;
            last_grant <= sel;
            cnt        <= '0;
            lat_addr   <= sel ? r1_addr  : r0_addr;
            lat_we     <= sel ? r1_we    : r0_we;
            lat_wdata  <= sel ? r1_wdata : r0_wdata;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            resp_data <= mem_read_data;
          end else if (timeout_hit) begin
            resp_data <= '0;
            err_q     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_valid        = (state == BUSY);
  assign mem_addr         = lat_addr;
  assign mem_write_data   = lat_wdata;
  assign mem_write_enable = lat_we & mem_valid;
  assign r0_ready         = (state == RESP) && !grant;
  assign r1_ready         = (state == RESP) &&  grant;
  assign r0_rdata         = resp_data;
  assign r1_rdata         = resp_data;
  assign err              = err_q;

endmodule
